// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO; one shift-add or
// restoring-division step per cycle, with pipeline stall generation.
module muldiv_sequencer #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             EX_MDStart,
   input  logic [1:0]       EX_MDOp,
   input  logic [WIDTH-1:0] EX_A,
   input  logic [WIDTH-1:0] EX_B,
   input  logic             EX_HiWrite,
   input  logic             EX_LoWrite,
   input  logic [WIDTH-1:0] EX_WData,
   input  logic             ID_HiLoRead,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO,
   output logic             MD_Busy,
   output logic             MD_EX_Stall,
   output logic             MD_ID_Stall
);

   localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN} state_t;

   state_t             r_state;
   state_t             w_next;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_div;
   logic               r_q_neg;
   logic               r_r_neg;
   logic               r_dz;
   logic [WIDTH-1:0]   r_acc_hi;
   logic [WIDTH-1:0]   r_acc_lo;
   logic [WIDTH-1:0]   r_b;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;

   logic               w_a_neg;
   logic               w_b_neg;
   logic [WIDTH-1:0]   w_a_mag;
   logic [WIDTH-1:0]   w_b_mag;
   logic [WIDTH:0]     w_mul_sum;
   logic [WIDTH:0]     w_div_shift;
   logic               w_div_ge;
   logic [WIDTH-1:0]   w_div_diff;
   logic [2*WIDTH-1:0] w_prod_fix;
   logic [WIDTH-1:0]   w_quo_fix;
   logic [WIDTH-1:0]   w_rem_fix;

   // Operand conditioning: signed ops work on magnitudes, sign fixed in FIN
   assign w_a_neg = ~EX_MDOp[0] & EX_A[WIDTH-1];
   assign w_b_neg = ~EX_MDOp[0] & EX_B[WIDTH-1];
   assign w_a_mag = w_a_neg ? (WIDTH'(0) - EX_A) : EX_A;
   assign w_b_mag = w_b_neg ? (WIDTH'(0) - EX_B) : EX_B;

   assign w_mul_sum   = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_b} : (WIDTH+1)'(0));
   assign w_div_shift = {r_acc_hi, r_acc_lo[WIDTH-1]};
   assign w_div_ge    = w_div_shift >= {1'b0, r_b};
   assign w_div_diff  = WIDTH'(w_div_shift - {1'b0, r_b});

   // Quotient of a divide-by-zero stays all ones regardless of operand sign
   assign w_prod_fix = r_q_neg ? ((2*WIDTH)'(0) - {r_acc_hi, r_acc_lo}) : {r_acc_hi, r_acc_lo};
   assign w_quo_fix  = (r_q_neg & ~r_dz) ? (WIDTH'(0) - r_acc_lo) : r_acc_lo;
   assign w_rem_fix  = r_r_neg ? (WIDTH'(0) - r_acc_hi) : r_acc_hi;

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (EX_MDStart) w_next = S_CALC;
         S_CALC:  if (r_cnt == CNT_W'(WIDTH-1)) w_next = S_FIN;
         S_FIN:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      MD_Busy     = 1'b0;
      MD_EX_Stall = 1'b0;
      MD_ID_Stall = 1'b0;
      MD_Busy     = (r_state != S_IDLE);
      MD_EX_Stall = MD_Busy & (EX_MDStart | EX_HiWrite | EX_LoWrite);
      MD_ID_Stall = ID_HiLoRead & (MD_Busy | EX_MDStart) & ~MD_EX_Stall;
   end

   // Datapath: accept/latch, iterate, then commit to HI/LO
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt    <= '0;
         r_div    <= 1'b0;
         r_q_neg  <= 1'b0;
         r_r_neg  <= 1'b0;
         r_dz     <= 1'b0;
         r_acc_hi <= '0;
         r_acc_lo <= '0;
         r_b      <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (EX_MDStart) begin
                  r_div    <= EX_MDOp[1];
                  r_q_neg  <= w_a_neg ^ w_b_neg;
                  r_r_neg  <= w_a_neg;
                  r_dz     <= (EX_B == '0);
                  r_acc_hi <= '0;
                  r_acc_lo <= w_a_mag;
                  r_b      <= w_b_mag;
                  r_cnt    <= '0;
               end else begin
                  if (EX_HiWrite) r_hi <= EX_WData;
                  if (EX_LoWrite) r_lo <= EX_WData;
               end
            end
            S_CALC: begin
               r_cnt <= r_cnt + CNT_W'(1);
               if (r_div) begin
                  r_acc_hi <= w_div_ge ? w_div_diff : w_div_shift[WIDTH-1:0];
                  r_acc_lo <= {r_acc_lo[WIDTH-2:0], w_div_ge};
               end else begin
                  r_acc_hi <= w_mul_sum[WIDTH:1];
                  r_acc_lo <= {w_mul_sum[0], r_acc_lo[WIDTH-1:1]};
               end
            end
            S_FIN: begin
               if (r_div) begin
                  r_hi <= w_rem_fix;
                  r_lo <= w_quo_fix;
               end else begin
                  r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                  r_lo <= w_prod_fix[WIDTH-1:0];
               end
            end
            default: ;
         endcase
      end
   end

   assign HI = r_hi;
   assign LO = r_lo;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: arithmetic reference model with
// a per-cycle compare process, directed scenarios and randomized traffic.
module tb_muldiv_sequencer;
   localparam int unsigned W = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          EX_MDStart;
   logic [1:0]    EX_MDOp;
   logic [W-1:0]  EX_A, EX_B, EX_WData;
   logic          EX_HiWrite, EX_LoWrite, ID_HiLoRead;
   logic [W-1:0]  HI, LO;
   logic          MD_Busy, MD_EX_Stall, MD_ID_Stall;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   logic chk_en = 1'b0;

   muldiv_sequencer #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .EX_MDStart(EX_MDStart), .EX_MDOp(EX_MDOp),
      .EX_A(EX_A), .EX_B(EX_B), .EX_HiWrite(EX_HiWrite), .EX_LoWrite(EX_LoWrite),
      .EX_WData(EX_WData), .ID_HiLoRead(ID_HiLoRead), .HI(HI), .LO(LO),
      .MD_Busy(MD_Busy), .MD_EX_Stall(MD_EX_Stall), .MD_ID_Stall(MD_ID_Stall)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at time %0t", name, act, exp, $time);
      end
   endtask

   // Reference arithmetic: returns {HI, LO}
   function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
      logic signed [63:0] sa, sb;
      logic signed [31:0] q, r;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      case (op)
         2'b00: return 64'(sa * sb);
         2'b01: return {32'b0, a} * {32'b0, b};
         2'b10: begin
            if (b == 0) return {a, 32'hFFFF_FFFF};
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
            return {r, q};
         end
         default: begin
            if (b == 0) return {a, 32'hFFFF_FFFF};
            return {a % b, a / b};
         end
      endcase
   endfunction

   // Behavioural model: busy countdown and pending result
   int          m_cnt = 0;
   logic [31:0] m_hi = '0, m_lo = '0;
   logic [63:0] m_pend = '0;

   always @(posedge clk) begin
      if (reset) begin
         m_cnt = 0; m_hi = '0; m_lo = '0;
      end else if (m_cnt > 0) begin
         m_cnt--;
         if (m_cnt == 0) {m_hi, m_lo} = m_pend;
      end else if (EX_MDStart) begin
         m_pend = ref_result(EX_MDOp, EX_A, EX_B);
         m_cnt  = W + 1;
      end else begin
         if (EX_HiWrite) m_hi = EX_WData;
         if (EX_LoWrite) m_lo = EX_WData;
      end
   end

   always @(negedge clk) begin
      logic e_busy, e_ex, e_id;
      if (chk_en) begin
         e_busy = (m_cnt != 0);
         e_ex   = e_busy & (EX_MDStart | EX_HiWrite | EX_LoWrite);
         e_id   = ID_HiLoRead & (e_busy | EX_MDStart) & ~e_ex;
         check("HI", 64'(HI), 64'(m_hi));
         check("LO", 64'(LO), 64'(m_lo));
         check("MD_Busy", 64'(MD_Busy), 64'(e_busy));
         check("MD_EX_Stall", 64'(MD_EX_Stall), 64'(e_ex));
         check("MD_ID_Stall", 64'(MD_ID_Stall), 64'(e_id));
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic idle_inputs();
      EX_MDStart = 0; EX_MDOp = 0; EX_A = 0; EX_B = 0;
      EX_HiWrite = 0; EX_LoWrite = 0; EX_WData = 0; ID_HiLoRead = 0;
   endtask

   // Present an EX instruction and hold it while MD_EX_Stall is high
   task automatic issue(input logic st, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic hw, input logic lw,
                        input logic [31:0] wd);
      logic held, done;
      done = 0;
      EX_MDStart = st; EX_MDOp = op; EX_A = a; EX_B = b;
      EX_HiWrite = hw; EX_LoWrite = lw; EX_WData = wd;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk); held = MD_EX_Stall;
         @(posedge clk); #1;
         if (!held) begin done = 1; break; end
      end
      if (!done) check("issue_timeout", 0, 1);
      idle_inputs();
   endtask

   // MFHI/MFLO held in ID until MD_ID_Stall drops; returns {HI, LO} then seen
   task automatic mf_read(output logic [63:0] val, output int stalls);
      logic done;
      done = 0; stalls = 0; val = '0;
      ID_HiLoRead = 1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (!MD_ID_Stall) begin val = {HI, LO}; done = 1; end
         else stalls++;
         @(posedge clk); #1;
         if (done) break;
      end
      if (!done) check("read_timeout", 0, 1);
      ID_HiLoRead = 0;
   endtask

   task automatic wait_idle();
      logic done;
      done = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (!MD_Busy) begin done = 1; break; end
      end
      if (!done) check("idle_timeout", 0, 1);
      @(posedge clk); #1;
   endtask

   task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
      issue(1, op, a, b, 0, 0, 0);
      wait_idle();
      check({name, "_HI"}, 64'(HI), 64'(eh));
      check({name, "_LO"}, 64'(LO), 64'(el));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          busy_cnt, t0, t1, t2, stalls;
      logic [63:0] rv;
      logic [31:0] ra, rb;
      idle_inputs();
      reset = 1;
      tick(); tick();
      chk_en = 1;
      check("rst_HI", 64'(HI), 0);
      check("rst_LO", 64'(LO), 0);
      check("rst_busy", 64'(MD_Busy), 0);
      reset = 0;
      tick();

      check("model_mult", ref_result(2'b00, 32'hFFFF_FFFE, 32'd3), 64'hFFFF_FFFF_FFFF_FFFA);
      check("model_div", ref_result(2'b10, 32'hFFFF_FFF9, 32'd2), 64'hFFFF_FFFF_FFFF_FFFD);

      // MULT -2 * 3 with busy-length measurement
      issue(1, 2'b00, 32'hFFFF_FFFE, 32'd3, 0, 0, 0);
      busy_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk); if (MD_Busy) busy_cnt++;
         @(posedge clk); #1;
      end
      check("mult_busy_cycles", 64'(busy_cnt), 64'd33);
      check("mult_HI", 64'(HI), 64'hFFFF_FFFF);
      check("mult_LO", 64'(LO), 64'hFFFF_FFFA);

      run_op("divu", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14);
      run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_op("div_zero", 2'b10, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF);
      run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
      run_op("div_zero_neg", 2'b10, 32'h8000_0005, 32'd0, 32'h8000_0005, 32'hFFFF_FFFF);

      // MFLO in ID during a MULTU
      issue(1, 2'b01, 32'h0001_0000, 32'h30, 0, 0, 0);
      tick(); tick();
      mf_read(rv, stalls);
      check("mflo_value", rv, 64'h0000_0000_0030_0000);
      check("mflo_stalled", 64'(stalls > 0), 1);

      // Back-to-back MULTU plus deferred MTHI
      issue(1, 2'b01, 32'd5, 32'd6, 0, 0, 0);
      t0 = cyc;
      tick(); tick();
      issue(1, 2'b01, 32'd7, 32'd9, 0, 0, 0);
      t1 = cyc;
      issue(0, 2'b00, 0, 0, 1, 0, 32'h0000_ABCD);
      t2 = cyc;
      check("b2b_accept_gap", 64'(t1 - t0), 64'd34);
      check("mthi_accept_gap", 64'(t2 - t1), 64'd34);
      check("b2b_HI", 64'(HI), 64'h0000_ABCD);
      check("b2b_LO", 64'(LO), 64'd63);

      // Start wins over a simultaneous MTHI
      issue(1, 2'b01, 32'd2, 32'd3, 1, 0, 32'hDEAD_BEEF);
      wait_idle();
      check("prio_HI", 64'(HI), 0);
      check("prio_LO", 64'(LO), 6);

      // Reset in the middle of a DIV
      issue(1, 2'b10, 32'd1000, 32'hFFFF_FFFD, 0, 0, 0);
      repeat (10) tick();
      reset = 1;
      tick();
      reset = 0;
      @(negedge clk);
      check("abort_busy", 64'(MD_Busy), 0);
      check("abort_HI", 64'(HI), 0);
      check("abort_LO", 64'(LO), 0);
      check("abort_stalls", 64'({MD_EX_Stall, MD_ID_Stall}), 0);
      @(posedge clk); #1;
      run_op("post_reset", 2'b01, 32'd3, 32'd4, 32'd0, 32'd12);

      // Randomized traffic; the per-cycle compare process does the checking
      for (int n = 0; n < 40; n++) begin
         int kind;
         kind = $urandom_range(0, 9);
         ra = $urandom;
         rb = $urandom;
         if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(0, 15));
         if ($urandom_range(0, 7) == 0) rb = 0;
         if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
         case (kind)
            0, 1, 2, 3, 4, 5: issue(1, 2'($urandom_range(0, 3)), ra, rb, 0, 0, 0);
            6: issue(0, 2'b00, 0, 0, 1, 0, ra);
            7: issue(0, 2'b00, 0, 0, 0, 1, ra);
            8: mf_read(rv, stalls);
            default: repeat ($urandom_range(1, 40)) tick();
         endcase
      end
      wait_idle();
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
